msg_streamer: RTL and testbench
===============================

MSG_STREAMER -- requirements
Module: msg_streamer

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, meaning ROM depth in characters (2..256).
REQ-002 The block SHALL have parameter MSG_LEN, default 13, meaning active message length in characters (1..MAX_LEN).
REQ-003 The block SHALL have parameter MSG, default "Hello, World!" (8*MAX_LEN bits, right-justified), meaning message content; char i = MSG[8*(MSG_LEN-1-i) +: 8].
REQ-004 The block SHALL have parameter GAP, default 2, meaning idle cycles between repetitions in continuous mode (0..255).
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin a transmission; sampled in IDLE only.
REQ-008 cont  input  1  mode, sampled with start: 0 = single message, 1 = repeat until stop.
REQ-009 stop  input  1  request to end continuous mode after the current message.
REQ-010 tx_data  output  8  current character.
REQ-011 tx_valid  output  1  tx_data is valid.
REQ-012 tx_ready  input  1  sink accepts; a transfer occurs on a cycle with tx_valid && tx_ready.
REQ-013 tx_last  output  1  high with the final character (index MSG_LEN-1) of each message.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse the cycle after the transfer that ends the whole run.
REQ-016 msg_cnt  output  16  number of complete messages sent since reset, wrapping 0xFFFF->0.

Function
REQ-017 FSM states SHALL be IDLE, SEND and GAP.
REQ-018 IDLE + start SHALL go to SEND next cycle with index=0, latching cont into an internal mode bit; start in any other state SHALL be ignored.
REQ-019 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal char[index], registered (no combinational path from tx_ready to tx_data/tx_valid).
REQ-020 tx_data and tx_valid SHALL hold stable while tx_valid && !tx_ready.
REQ-021 Each transfer with index<MSG_LEN-1 SHALL increment index; back-to-back transfers SHALL sustain one character per cycle.
REQ-022 tx_last SHALL be 1 exactly when in SEND with index==MSG_LEN-1; MSG_LEN=1 gives tx_last on every character.
REQ-023 On the tx_last transfer, msg_cnt SHALL increment by 1.
REQ-024 On the tx_last transfer, with mode=0 or a pending stop, the FSM SHALL go to IDLE and pulse done the following cycle.
REQ-025 On the tx_last transfer, with mode=1 and no pending stop, the FSM SHALL go to GAP for GAP cycles and then to SEND with index=0; GAP=0 SHALL go directly to SEND index=0 with no bubble.
REQ-026 A stop seen in SEND SHALL set a pending flag, cleared on entry to IDLE.
REQ-027 A stop seen in GAP SHALL go to IDLE next cycle with a done pulse; the message in progress is never truncated.
REQ-028 If stop and the tx_last transfer occur in the same cycle, the FSM SHALL end the run (go to IDLE, pulse done).
REQ-029 stop in IDLE SHALL be ignored and SHALL not set the pending flag.
REQ-030 tx_valid SHALL be 0 in IDLE and GAP; tx_data is don't-care there and SHALL be driven 0.
REQ-031 The latency from start high to first tx_valid SHALL be exactly 1 cycle.

Reset
REQ-032 While rst=1, outputs SHALL be: tx_data=0, tx_valid=0, tx_last=0, busy=0, done=0, msg_cnt=0; FSM=IDLE, index=0, mode=0, pending stop=0.
REQ-033 rst asserted mid-message SHALL abort immediately, with no done pulse and no msg_cnt increment; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-034 Default params, start (cont=0), tx_ready=1 -> 13 consecutive bytes 0x48..0x21 ("Hello, World!"), tx_last on byte 13, done 1 cycle later, msg_cnt=1, busy low.
REQ-035 tx_ready toggling randomly 50% -> same byte sequence, no drop/duplicate, tx_data stable during each stall.
REQ-036 cont=1, GAP=2, stop asserted during message 3 -> messages separated by exactly 2 idle cycles, message 3 completes, done pulse, msg_cnt=3.
REQ-037 GAP=0 continuous, stop coincident with the tx_last transfer of message 1 -> run ends after message 1, msg_cnt=1, no byte of message 2.
REQ-038 rst pulsed after the 5th byte of a message -> all outputs 0 the same cycle, msg_cnt=0, no done; a new start -> full message from 'H'.
REQ-039 MSG_LEN=1, MSG="A", cont=0 -> a single 0x41 with tx_last=1, done next cycle; start held high during SEND is ignored.

Source files
------------

// File: rtl/msg_streamer_if.sv
// Character stream bus between the message streamer (master) and its sink (slave).
interface msg_streamer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_last;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );
endinterface

// File: rtl/msg_streamer.sv
// Message streamer: sends a fixed character string from a parameter ROM over a
// valid/ready stream, either once or repeatedly with idle gaps until stopped.
// All stream outputs are registered, so tx_ready never reaches tx_data/tx_valid
// combinationally.
module msg_streamer #(
    parameter int                   MAX_LEN = 16,
    parameter int                   MSG_LEN = 13,
    parameter logic [8*MAX_LEN-1:0] MSG     = (8*MAX_LEN)'("Hello, World!"),
    parameter int                   GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cont,
    input  logic                  stop,
    msg_streamer_if.master        tx,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           msg_cnt
);

    localparam int            IW            = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX      = IW'(MSG_LEN - 1);
    localparam logic [7:0]    GAP_LOAD      = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam logic          FIRST_IS_LAST = (MSG_LEN == 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_index;
    logic          r_mode;
    logic          r_stopPend;
    logic [7:0]    r_gapCnt;
    logic [7:0]    r_txData;
    logic          r_txValid;
    logic          r_txLast;
    logic          r_busy;
    logic          r_done;
    logic [15:0]   r_msgCnt;

    logic [7:0]    w_rom [MAX_LEN];
    logic          w_xfer;
    logic [IW-1:0] w_nextIndex;

    // Unpack the right-justified message parameter into one byte per index;
    // character 0 sits in the most significant used byte.
    for (genvar g = 0; g < MAX_LEN; g++) begin : g_rom
        if (g < MSG_LEN) begin : g_used
            assign w_rom[g] = MSG[8*(MSG_LEN-1-g) +: 8];
        end else begin : g_unused
            assign w_rom[g] = 8'd0;
        end
    end

    // tx_valid is only ever high in SEND, so a handshake implies SEND.
    assign w_xfer      = r_txValid && tx.tx_ready;
    assign w_nextIndex = r_index + IW'(1);

    // Control FSM with every output registered; a stalled character holds
    // because nothing is loaded unless a transfer happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_index    <= '0;
            r_mode     <= 1'b0;
            r_stopPend <= 1'b0;
            r_gapCnt   <= 8'd0;
            r_txData   <= 8'd0;
            r_txValid  <= 1'b0;
            r_txLast   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_msgCnt   <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_SEND;
                        r_index    <= '0;
                        r_mode     <= cont;
                        r_stopPend <= 1'b0;
                        r_txData   <= w_rom[0];
                        r_txValid  <= 1'b1;
                        r_txLast   <= FIRST_IS_LAST;
                        r_busy     <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (w_xfer && r_txLast) begin
                        r_msgCnt <= r_msgCnt + 16'd1;
                        if (!r_mode || r_stopPend || stop) begin
                            r_state    <= S_IDLE;
                            r_index    <= '0;
                            r_stopPend <= 1'b0;
                            r_txData   <= 8'd0;
                            r_txValid  <= 1'b0;
                            r_txLast   <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else if (GAP == 0) begin
                            r_index  <= '0;
                            r_txData <= w_rom[0];
                            r_txLast <= FIRST_IS_LAST;
                        end else begin
                            r_state   <= S_GAP;
                            r_gapCnt  <= GAP_LOAD;
                            r_index   <= '0;
                            r_txData  <= 8'd0;
                            r_txValid <= 1'b0;
                            r_txLast  <= 1'b0;
                        end
                    end else begin
                        if (stop) begin
                            r_stopPend <= 1'b1;
                        end
                        if (w_xfer) begin
                            r_index  <= w_nextIndex;
                            r_txData <= w_rom[w_nextIndex];
                            r_txLast <= (w_nextIndex == LAST_IDX);
                        end
                    end
                end

                S_GAP: begin
                    if (stop) begin
                        r_state    <= S_IDLE;
                        r_stopPend <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (r_gapCnt == 8'd0) begin
                        r_state   <= S_SEND;
                        r_index   <= '0;
                        r_txData  <= w_rom[0];
                        r_txValid <= 1'b1;
                        r_txLast  <= FIRST_IS_LAST;
                    end else begin
                        r_gapCnt <= r_gapCnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx.tx_data  = r_txData;
    assign tx.tx_valid = r_txValid;
    assign tx.tx_last  = r_txLast;
    assign busy        = r_busy;
    assign done        = r_done;
    assign msg_cnt     = r_msgCnt;

endmodule

// File: tb/tb_msg_streamer.sv
// Bench for msg_streamer: three instances (default, GAP=0, one-character message)
// driven with randomized back-pressure and stop timing, checked against a
// message-level model of the expected byte stream, gaps, done timing and count.
module tb_msg_streamer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       cont  = 1'b0;
    logic       stop  = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] sel   = 2'd0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    string msgText  [3] = '{"Hello, World!", "Hello, World!", "A"};
    int    gapOf    [3] = '{2, 0, 2};
    int    cntModel [3] = '{0, 0, 0};

    logic        busyA, busyB, busyC;
    logic        doneA, doneB, doneC;
    logic [15:0] cntA, cntB, cntC;

    logic [7:0]  oData;
    logic        oValid, oLast, oBusy, oDone;
    logic [15:0] oCnt;

    msg_streamer_if ifA ();
    msg_streamer_if ifB ();
    msg_streamer_if ifC ();

    assign ifA.tx_ready = ready;
    assign ifB.tx_ready = ready;
    assign ifC.tx_ready = ready;

    msg_streamer dutA (
        .clk(clk), .rst(rst), .start(start && (sel == 2'd0)), .cont(cont), .stop(stop),
        .tx(ifA), .busy(busyA), .done(doneA), .msg_cnt(cntA)
    );

    msg_streamer #(.GAP(0)) dutB (
        .clk(clk), .rst(rst), .start(start && (sel == 2'd1)), .cont(cont), .stop(stop),
        .tx(ifB), .busy(busyB), .done(doneB), .msg_cnt(cntB)
    );

    msg_streamer #(.MAX_LEN(2), .MSG_LEN(1), .MSG(16'h0041), .GAP(2)) dutC (
        .clk(clk), .rst(rst), .start(start && (sel == 2'd2)), .cont(cont), .stop(stop),
        .tx(ifC), .busy(busyC), .done(doneC), .msg_cnt(cntC)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Route the outputs of the instance under test to one set of observation signals.
    always_comb begin
        oData  = ifA.tx_data;
        oValid = ifA.tx_valid;
        oLast  = ifA.tx_last;
        oBusy  = busyA;
        oDone  = doneA;
        oCnt   = cntA;
        if (sel == 2'd1) begin
            oData  = ifB.tx_data;
            oValid = ifB.tx_valid;
            oLast  = ifB.tx_last;
            oBusy  = busyB;
            oDone  = doneB;
            oCnt   = cntB;
        end else if (sel == 2'd2) begin
            oData  = ifC.tx_data;
            oValid = ifC.tx_valid;
            oLast  = ifC.tx_last;
            oBusy  = busyC;
            oDone  = doneC;
            oCnt   = cntC;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One run on instance s. stopWhere: 0 none, 1 mid-message stopMsg,
    // 2 together with the last transfer of stopMsg, 3 in the gap after stopMsg.
    task automatic applyStimulus(input logic [1:0] s, input logic useCont, input int readyPct,
                                 input int stopWhere, input int stopMsg, input logic holdStart);
        string      txt;
        int         len, expMsgs, msgs, pos, stopPos, doneCycle, expDoneCycle, gapRun;
        bit         stopSent, doneSeen, inGap, stalled;
        logic [7:0] stallData;
        logic [7:0] got [$];
        logic       gotLast [$];
        int         gaps [$];

        sel          = s;
        txt          = msgText[s];
        len          = txt.len();
        expMsgs      = useCont ? stopMsg : 1;
        msgs         = 0;
        pos          = 0;
        stopPos      = (len > 2) ? int'($urandom_range(len - 2, 1)) : 0;
        doneCycle    = -1;
        expDoneCycle = -2;
        gapRun       = 0;
        stopSent     = 1'b0;
        doneSeen     = 1'b0;
        inGap        = 1'b0;
        stalled      = 1'b0;
        stallData    = 8'd0;

        start = 1'b1;
        cont  = useCont;
        stop  = 1'b0;
        ready = 1'b0;
        tick();
        start = holdStart;
        checkOutput("firstValid", {31'd0, oValid}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            if (c > 0) tick();
            stop = 1'b0;
            if (stalled) begin
                checkOutput("stallHold", {23'd0, oValid, oData}, {23'd0, 1'b1, stallData});
            end
            if (inGap && oValid) begin
                gaps.push_back(gapRun);
                inGap = 1'b0;
            end else if (inGap) begin
                gapRun++;
            end
            if (oDone) begin
                doneSeen  = 1'b1;
                doneCycle = cyc;
                checkOutput("doneBusy", {31'd0, oBusy}, 32'd0);
                checkOutput("doneValid", {31'd0, oValid}, 32'd0);
                checkOutput("msgCnt", {16'd0, oCnt}, {16'd0, 16'(cntModel[s] + expMsgs)});
                break;
            end
            ready = ($urandom_range(99, 0) < readyPct);
            if (stopWhere == 1 && !stopSent && oValid && msgs == stopMsg - 1 && pos >= stopPos) begin
                stop     = 1'b1;
                stopSent = 1'b1;
            end
            if (stopWhere == 2 && !stopSent && oValid && oLast && msgs == stopMsg - 1) begin
                stop     = 1'b1;
                ready    = 1'b1;
                stopSent = 1'b1;
            end
            if (stopWhere == 3 && !stopSent && oBusy && !oValid && msgs == stopMsg) begin
                stop         = 1'b1;
                stopSent     = 1'b1;
                expDoneCycle = cyc + 1;
            end
            stalled   = oValid && !ready;
            stallData = oData;
            if (oValid && ready) begin
                got.push_back(oData);
                gotLast.push_back(oLast);
                pos++;
                if (oLast) begin
                    msgs++;
                    pos          = 0;
                    expDoneCycle = cyc + 1;
                    inGap        = 1'b1;
                    gapRun       = 0;
                    start        = 1'b0;
                end
            end
        end

        ready = 1'b0;
        stop  = 1'b0;
        start = 1'b0;
        cntModel[s] = cntModel[s] + expMsgs;

        checkOutput("doneSeen", {31'd0, doneSeen}, 32'd1);
        checkOutput("doneCycle", doneCycle, expDoneCycle);
        checkOutput("msgCount", msgs, expMsgs);
        checkOutput("byteCount", got.size(), expMsgs * len);
        foreach (got[i]) begin
            checkOutput("byte", {24'd0, got[i]}, {24'd0, 8'(txt[i % len])});
            checkOutput("lastFlag", {31'd0, gotLast[i]}, {31'd0, ((i % len) == len - 1)});
        end
        checkOutput("gapCount", gaps.size(), expMsgs - 1);
        foreach (gaps[i]) begin
            checkOutput("gapLen", gaps[i], gapOf[s]);
        end
        tick();
        checkOutput("donePulseEnd", {31'd0, oDone}, 32'd0);
        checkOutput("idleBusy", {31'd0, oBusy}, 32'd0);
        checkOutput("idleValid", {31'd0, oValid}, 32'd0);
        checkOutput("idleData", {24'd0, oData}, 32'd0);
    endtask

    // Directed sequence of randomized runs.
    initial begin
        sel = 2'd0;
        #1 rst = 1'b1;
        #2;
        checkOutput("rstData", {24'd0, oData}, 32'd0);
        checkOutput("rstValid", {31'd0, oValid}, 32'd0);
        checkOutput("rstLast", {31'd0, oLast}, 32'd0);
        checkOutput("rstBusy", {31'd0, oBusy}, 32'd0);
        checkOutput("rstDone", {31'd0, oDone}, 32'd0);
        checkOutput("rstCnt", {16'd0, oCnt}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        applyStimulus(2'd0, 1'b0, 100, 0, 0, 1'b0);
        applyStimulus(2'd0, 1'b0, 50, 0, 0, 1'b0);
        applyStimulus(2'd0, 1'b1, 70, 1, 3, 1'b0);
        applyStimulus(2'd0, 1'b1, 60, 3, 2, 1'b0);

        applyStimulus(2'd1, 1'b1, 100, 2, 1, 1'b0);
        sel  = 2'd1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checkOutput("idleStopBusy", {31'd0, oBusy}, 32'd0);
        applyStimulus(2'd1, 1'b1, 80, 2, 2, 1'b0);

        sel   = 2'd0;
        start = 1'b1;
        cont  = 1'b0;
        ready = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checkOutput("preRstByte", {24'd0, oData}, {24'd0, 8'h2C});
        rst = 1'b1;
        #1;
        checkOutput("abortData", {24'd0, oData}, 32'd0);
        checkOutput("abortValid", {31'd0, oValid}, 32'd0);
        checkOutput("abortBusy", {31'd0, oBusy}, 32'd0);
        checkOutput("abortCnt", {16'd0, oCnt}, 32'd0);
        cntModel = '{0, 0, 0};
        tick();
        ready = 1'b0;
        rst   = 1'b0;
        tick();
        checkOutput("abortNoDone", {31'd0, oDone}, 32'd0);
        tick();
        checkOutput("abortWaitIdle", {31'd0, oBusy}, 32'd0);
        applyStimulus(2'd0, 1'b0, 100, 0, 0, 1'b0);

        applyStimulus(2'd2, 1'b0, 50, 0, 0, 1'b1);
        applyStimulus(2'd2, 1'b0, 100, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
